// File: rtl/isa_host_if_pkg.sv
// -----------------------------------------------------------------------------
// isa_host_if_pkg
// Shared definitions for the ISA host interface: I/O register offsets inside
// the 16-byte window, the VRAM handshake state encoding and the write mask
// applied to control register 0.
// Ports: none (package).
// -----------------------------------------------------------------------------
package isa_host_if_pkg;

    localparam logic [3:0] OFF_CRTC_IDX  = 4'h4;
    localparam logic [3:0] OFF_CRTC_DATA = 4'h5;
    localparam logic [3:0] OFF_CTRL_BASE = 4'h8;
    localparam logic [3:0] OFF_STATUS    = 4'hA;
    localparam logic [3:0] OFF_CONFIG    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } mem_state_t;

    // Bit 7 (window page select) and bit 1 are only writable once the
    // matching config bit has been set; otherwise they are stored as 0.
    function automatic logic [7:0] mask_ctrl0(input logic [7:0] data,
                                              input logic [1:0] cfg);
        return {data[7] & cfg[1], data[6:2], data[1] & cfg[0], data[0]};
    endfunction

endpackage

// File: rtl/isa_host_if_if.sv
// -----------------------------------------------------------------------------
// isa_host_if_if
// ISA bus bundle between the host (master) and the card (slave).
// Signals: bus_a[19:0] address, bus_d[7:0] write data, bus_aen DMA address
// enable, bus_ior_l/bus_iow_l/bus_memr_l/bus_memw_l active-low strobes,
// bus_out[7:0] card read data, bus_dir high while the card drives the bus.
// -----------------------------------------------------------------------------
interface isa_host_if_if;
    import isa_host_if_pkg::*;

    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_aen;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic [7:0]  bus_out;
    logic        bus_dir;

    modport master (
        output bus_a, bus_d, bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
        input  bus_out, bus_dir
    );

    modport slave (
        input  bus_a, bus_d, bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
        output bus_out, bus_dir
    );

endinterface

// File: rtl/isa_strobe_sync.sv
// -----------------------------------------------------------------------------
// isa_strobe_sync
// Brings one asynchronous active-low ISA strobe into the clk domain and flags
// its falling edge once, regardless of how long the strobe stays low.
// Ports: clk, reset (sync, active-high), strobe_l (async strobe),
//        sync_l (synchronised level), fall (one-cycle falling-edge flag).
// -----------------------------------------------------------------------------
module isa_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_l,
    output logic sync_l,
    output logic fall
);
    import isa_host_if_pkg::*;

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   prev_r;

    // Synchroniser chain plus one delayed copy for edge detection; idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {SYNC_STAGES{1'b1}};
            prev_r  <= 1'b1;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], strobe_l};
            prev_r  <= chain_r[SYNC_STAGES-1];
        end
    end

    assign sync_l = chain_r[SYNC_STAGES-1];
    // Both operands are flops, so the flag is a clean single-cycle pulse.
    assign fall   = prev_r & ~chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/isa_host_if.sv
// -----------------------------------------------------------------------------
// isa_host_if
// ISA slave for a display card: 16-byte I/O window (CRTC index/data, control
// registers, status, config) and a 32 KB memory window forwarded to VRAM via a
// request/acknowledge handshake. Optional macro ISA_CTRL_READBACK_EN makes the
// control and config registers readable.
// Ports: clk, reset (sync, active-high); bus (isa_host_if_if.slave);
//        status_in, crtc_rdata (read sources); crtc_idx, crtc_wr, crtc_wdata
//        (CRTC access); ctrl (control registers); mem_req, mem_we, mem_addr,
//        mem_wdata, mem_ack, mem_rdata (VRAM handshake).
// -----------------------------------------------------------------------------
module isa_host_if
    import isa_host_if_pkg::*;
#(
    parameter logic [19:0] IO_BASE     = 20'h3B0,
    parameter int          NUM_CTRL    = 2,
    parameter logic [31:0] CTRL_RESET  = {4{8'h28}},
    parameter logic [4:0]  MEM_BASE    = 5'b10110,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    isa_host_if_if.slave          bus,
    input  logic [7:0]            status_in,
    input  logic [7:0]            crtc_rdata,
    output logic [4:0]            crtc_idx,
    output logic                  crtc_wr,
    output logic [7:0]            crtc_wdata,
    output logic [8*NUM_CTRL-1:0] ctrl,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [15:0]           mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    localparam logic [2:0] NUM_CTRL_W = 3'(NUM_CTRL);

    logic ior_sync_s, ior_fall_s, iow_sync_s, iow_fall_s;
    logic memr_sync_s, memr_fall_s, memw_sync_s, memw_fall_s;
    logic unused_s;

    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ior (
        .clk(clk), .reset(reset), .strobe_l(bus.bus_ior_l), .sync_l(ior_sync_s), .fall(ior_fall_s));
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_iow (
        .clk(clk), .reset(reset), .strobe_l(bus.bus_iow_l), .sync_l(iow_sync_s), .fall(iow_fall_s));
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_memr (
        .clk(clk), .reset(reset), .strobe_l(bus.bus_memr_l), .sync_l(memr_sync_s), .fall(memr_fall_s));
    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_memw (
        .clk(clk), .reset(reset), .strobe_l(bus.bus_memw_l), .sync_l(memw_sync_s), .fall(memw_fall_s));

    // I/O reads are served combinationally, so the synchronised read strobe
    // has no consumer; only the level of memr is needed to leave HOLD.
    assign unused_s = ^{ior_sync_s, ior_fall_s, iow_sync_s, memw_sync_s};

    logic [8*NUM_CTRL-1:0] ctrl_r;
    logic [1:0]            cfg_r;
    logic [4:0]            crtc_idx_r;
    logic                  crtc_wr_r;
    logic [7:0]            crtc_wdata_r;

    logic       io_sel_s, ctrl_hit_s, mem_sel_s;
    logic [3:0] off_s;

    assign off_s      = bus.bus_a[3:0];
    assign io_sel_s   = ~bus.bus_aen && (bus.bus_a[19:4] == IO_BASE[19:4]);
    assign ctrl_hit_s = (off_s[3:2] == OFF_CTRL_BASE[3:2]) && ({1'b0, off_s[1:0]} < NUM_CTRL_W);
    // Control bit 7 flips the window to the upper 32 KB page.
    assign mem_sel_s  = (bus.bus_a[19:16] == MEM_BASE[4:1]) &&
                        (bus.bus_a[15] == (MEM_BASE[0] | ctrl_r[7]));

    // I/O write side: CRTC index/data, control registers and config.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r       <= CTRL_RESET[8*NUM_CTRL-1:0];
            cfg_r        <= 2'b00;
            crtc_idx_r   <= 5'd0;
            crtc_wr_r    <= 1'b0;
            crtc_wdata_r <= 8'h00;
        end else begin
            crtc_wr_r <= 1'b0;
            if (iow_fall_s && io_sel_s) begin
                case (off_s)
                    OFF_CRTC_IDX:  crtc_idx_r <= bus.bus_d[4:0];
                    OFF_CRTC_DATA: begin
                        crtc_wr_r    <= 1'b1;
                        crtc_wdata_r <= bus.bus_d;
                    end
                    OFF_CONFIG:    cfg_r <= bus.bus_d[1:0];
                    default:       ;
                endcase
                if (ctrl_hit_s) begin
                    for (int i = 0; i < NUM_CTRL; i++) begin
                        if (off_s[1:0] == 2'(i)) begin
                            ctrl_r[8*i +: 8] <= (i == 0) ? mask_ctrl0(bus.bus_d, cfg_r) : bus.bus_d;
                        end
                    end
                end
            end
        end
    end

    mem_state_t state_r, state_nx_s;
    logic       start_s, capture_s;
    logic       mem_req_r, mem_we_r;
    logic [15:0] mem_addr_r;
    logic [7:0]  mem_wdata_r, rdata_r;

    // VRAM handshake state register and request/data latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 8'h00;
            rdata_r     <= 8'h00;
        end else begin
            state_r   <= state_nx_s;
            mem_req_r <= (state_nx_s == ST_REQ);
            if (start_s) begin
                mem_addr_r  <= bus.bus_a[15:0];
                mem_we_r    <= memw_fall_s;
                mem_wdata_r <= bus.bus_d;
            end
            if (capture_s) begin
                rdata_r <= mem_rdata;
            end
        end
    end

    // VRAM handshake next state; edges seen outside IDLE are dropped.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((memr_fall_s || memw_fall_s) && mem_sel_s) begin
                    start_s    = 1'b1;
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    capture_s  = ~mem_we_r;
                    state_nx_s = mem_we_r ? ST_IDLE : ST_HOLD;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (memr_sync_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    logic [7:0] bus_out_s;
    logic       bus_dir_s;
`ifdef ISA_CTRL_READBACK_EN
    logic [7:0] ctrl_rd_s;

    // Select the addressed control register for readback.
    always_comb begin
        ctrl_rd_s = 8'h00;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (off_s[1:0] == 2'(i)) begin
                ctrl_rd_s = ctrl_r[8*i +: 8];
            end else begin
                ctrl_rd_s = ctrl_rd_s;
            end
        end
    end
`endif

    // Read data and bus direction follow the raw strobes so the host sees
    // data within its own read cycle.
    always_comb begin
        bus_out_s = 8'h00;
        bus_dir_s = 1'b0;
        if (!bus.bus_memr_l && mem_sel_s) begin
            bus_out_s = rdata_r;
            bus_dir_s = 1'b1;
        end else if (!bus.bus_ior_l && io_sel_s && off_s == OFF_STATUS) begin
            bus_out_s = status_in;
            bus_dir_s = 1'b1;
        end else if (!bus.bus_ior_l && io_sel_s && off_s == OFF_CRTC_DATA) begin
            bus_out_s = crtc_rdata;
            bus_dir_s = 1'b1;
`ifdef ISA_CTRL_READBACK_EN
        end else if (!bus.bus_ior_l && io_sel_s && off_s == OFF_CONFIG) begin
            bus_out_s = {6'b000000, cfg_r};
            bus_dir_s = 1'b1;
        end else if (!bus.bus_ior_l && io_sel_s && ctrl_hit_s) begin
            bus_out_s = ctrl_rd_s;
            bus_dir_s = 1'b1;
`endif
        end else begin
            bus_out_s = 8'h00;
            bus_dir_s = 1'b0;
        end
    end

    assign bus.bus_out = bus_out_s;
    assign bus.bus_dir = bus_dir_s;
    assign crtc_idx    = crtc_idx_r;
    assign crtc_wr     = crtc_wr_r;
    assign crtc_wdata  = crtc_wdata_r;
    assign ctrl        = ctrl_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;

endmodule
